sid_dac_sched: RTL
==================

SID_DAC_SCHED -- requirements
Module: sid_dac_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one bit-serial SID DAC engine (range 2..8).
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Port req  input  NREQ  SHALL carry the per-requester conversion requests; bit n belongs to requester n.
REQ-005 Port vin  input  12*NREQ  SHALL carry the DAC input codes; requester n uses bits [12n+11:12n], right-aligned.
REQ-006 Port kind  input  2*NREQ  SHALL select the DAC per requester: 0 = waveform (12 bit), 1 = envelope (8 bit), 2 = cutoff (11 bit), 3 = treated as 0.
REQ-007 Port ack  output  NREQ  SHALL pulse a one-cycle completion strobe to the served requester.
REQ-008 Port vout  output  12  SHALL carry the converted value, right-aligned and zero-extended; it is valid while any ack bit is high.
REQ-009 Port vout_id  output  3  SHALL carry the index of the requester served by the current vout.
REQ-010 Port busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-012 In IDLE with any unmasked req high, the block SHALL grant using round-robin order starting at last_grant+1.
- On grant it SHALL latch vin, kind and the grant index.
- It SHALL load acc = 8 (0.5 LSB rounding with 4 scale bits), set idx = 0, and enter RUN.
REQ-013 In RUN, each cycle SHALL add weight[kind][idx] to acc when latched vin[idx] = 1, then increment idx.
- After bit BITS(kind)-1, the block SHALL return to IDLE.
REQ-014 acc SHALL be 16 bits wide and SHALL never overflow for any code.
REQ-015 In the cycle after the last RUN cycle:
- vout SHALL equal acc[BITS+3:4].
- ack[id] SHALL be 1 and vout_id SHALL equal id.
- The state SHALL be IDLE.
REQ-016 Latency: a req first seen in IDLE at edge T SHALL be acked in cycle T+BITS+1 (waveform 13, envelope 9, cutoff 12 cycles); throughput is one conversion per BITS+1 cycles.
REQ-017 The requester whose ack is high SHALL be masked from arbitration in that cycle, so a held req does not cause a double grant.
- The requester SHALL drop req in its ack cycle, or it is re-queued on the next cycle.
REQ-018 Changes to req, vin or kind during RUN SHALL NOT affect the conversion in progress.
REQ-019 With several simultaneous requests, each requester SHALL be served within NREQ conversions (starvation-free).
REQ-020 vout and vout_id SHALL hold their last values between acks; ack SHALL be 0 otherwise.
REQ-021 The 6581 weights (hex, bit 0 first) SHALL be:
- waveform: 21 30 55 a0 135 256 486 8c6 1102 20f8 3fec 7bed
- envelope: 1d 2a 4b 8d 110 20e 3fb 7b8
- cutoff: 20 2f 52 9c 12b 243 463 880 107b 1ff4 3df3

Reset
REQ-022 rst high SHALL immediately force state IDLE, ack = 0, vout = 0, vout_id = 0, busy = 0, acc = 0, idx = 0, and last_grant = NREQ-1 (requester 0 has first priority).
REQ-023 A reset during RUN SHALL abandon the conversion with no ack; the first grant after release SHALL follow REQ-022 priority.

Configuration
REQ-024 With macro SID_DAC_SCHED_8580_EN defined, the block SHALL use ideal 8580 weights, weight[k][i] = 1 << (i+4) for all kinds, so vout = vin masked to BITS(kind).
REQ-025 With SID_DAC_SCHED_8580_EN undefined, the block SHALL use the 6581 tables of REQ-021.

Verification
REQ-026 Bench SHALL cover: 6581, req[0] with kind 0 and vin 0x001 -> ack[0] 13 cycles later, vout = 0x002; vin 0x800 -> vout = 0x7bf.
REQ-027 Bench SHALL cover: 6581, kind 1 with vin 0xFF -> vout = 0x0FF after 9 cycles; kind 2 with vin 0x400 -> vout = 0x3df after 12 cycles.
REQ-028 Bench SHALL cover: req = 4'b1111 held, each requester dropping req on its ack -> acks in order 0,1,2,3 with no repeats and busy continuously high except in ack cycles.
REQ-029 Bench SHALL cover: rst pulsed at RUN cycle 5 -> no ack, busy = 0 immediately; after release, req = 4'b1010 -> requester 1 served first.
REQ-030 Bench SHALL cover: SID_DAC_SCHED_8580_EN defined, random vin and kind -> vout equals vin truncated to BITS(kind) for 1000 conversions.
REQ-031 Bench SHALL cover: vin/kind toggled every cycle during RUN -> result matches the values latched at grant.

Source files
------------

// File: rtl/sid_dac_sched.sv
// rtl/sid_dac_sched.sv - round-robin scheduler for a shared bit-serial SID DAC engine
// Define SID_DAC_SCHED_8580_EN for ideal binary-weighted 8580 DACs instead of the 6581 tables.
module sid_dac_sched #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [12*NREQ-1:0]   vin,
    input  logic [2*NREQ-1:0]    kind,
    output logic [NREQ-1:0]      ack,
    output logic [11:0]          vout,
    output logic [2:0]           vout_id,
    output logic                 busy
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [11:0] vin_r;
    logic [1:0]  kind_r;
    logic [2:0]  gid_r;
    logic [2:0]  last_grant;
    logic [15:0] acc;
    logic [3:0]  idx;

    function automatic logic [3:0] bits_of(input logic [1:0] k);
        case (k)
            2'd1:    return 4'd8;
            2'd2:    return 4'd11;
            default: return 4'd12;
        endcase
    endfunction

    function automatic logic [11:0] code_mask(input logic [1:0] k);
        case (k)
            2'd1:    return 12'h0ff;
            2'd2:    return 12'h7ff;
            default: return 12'hfff;
        endcase
    endfunction

`ifndef SID_DAC_SCHED_8580_EN
    // Measured 6581 ladder weights, 4 fractional bits, bit 0 first.
    function automatic logic [15:0] weight6581(input logic [1:0] k, input logic [3:0] i);
        logic [15:0] w;
        w = 16'd0;
        case (k)
            2'd1: case (i)
                4'd0: w = 16'h001d;  4'd1: w = 16'h002a;  4'd2: w = 16'h004b;  4'd3: w = 16'h008d;
                4'd4: w = 16'h0110;  4'd5: w = 16'h020e;  4'd6: w = 16'h03fb;  4'd7: w = 16'h07b8;
                default: w = 16'd0;
            endcase
            2'd2: case (i)
                4'd0: w = 16'h0020;  4'd1: w = 16'h002f;  4'd2: w = 16'h0052;  4'd3: w = 16'h009c;
                4'd4: w = 16'h012b;  4'd5: w = 16'h0243;  4'd6: w = 16'h0463;  4'd7: w = 16'h0880;
                4'd8: w = 16'h107b;  4'd9: w = 16'h1ff4;  4'd10: w = 16'h3df3;
                default: w = 16'd0;
            endcase
            default: case (i)
                4'd0: w = 16'h0021;  4'd1: w = 16'h0030;  4'd2: w = 16'h0055;  4'd3: w = 16'h00a0;
                4'd4: w = 16'h0135;  4'd5: w = 16'h0256;  4'd6: w = 16'h0486;  4'd7: w = 16'h08c6;
                4'd8: w = 16'h1102;  4'd9: w = 16'h20f8;  4'd10: w = 16'h3fec; 4'd11: w = 16'h7bed;
                default: w = 16'd0;
            endcase
        endcase
        return w;
    endfunction
`endif

    logic [7:0]  pend;
    logic [3:0]  cand;
    logic        found;
    logic [2:0]  pick;
    logic [11:0] sel_vin;
    logic [1:0]  sel_kind;

    // Round-robin search from last_grant+1; the requester being acked is masked out.
    always_comb begin
        pend     = 8'(req & ~ack);
        cand     = 4'd0;
        found    = 1'b0;
        pick     = 3'd0;
        sel_vin  = 12'd0;
        sel_kind = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, last_grant} + 4'd1 + 4'(i);
            if (cand >= 4'(NREQ))
                cand = cand - 4'(NREQ);
            if (!found && pend[cand[2:0]]) begin
                found = 1'b1;
                pick  = cand[2:0];
            end
        end
        for (int n = 0; n < NREQ; n++) begin
            if (3'(n) == pick) begin
                sel_vin  = vin[12*n +: 12];
                sel_kind = kind[2*n +: 2];
            end
        end
    end

    logic [15:0] wsel;
    logic [15:0] acc_nx;
    logic        last_bit;

`ifdef SID_DAC_SCHED_8580_EN
    assign wsel = 16'd1 << (idx + 4'd4);
`else
    assign wsel = weight6581(kind_r, idx);
`endif

    assign acc_nx   = acc + (vin_r[idx] ? wsel : 16'd0);
    assign last_bit = (idx == bits_of(kind_r) - 4'd1);
    assign busy     = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ack        <= '0;
            vout       <= 12'd0;
            vout_id    <= 3'd0;
            acc        <= 16'd0;
            idx        <= 4'd0;
            vin_r      <= 12'd0;
            kind_r     <= 2'd0;
            gid_r      <= 3'd0;
            last_grant <= 3'(NREQ - 1);
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        vin_r      <= sel_vin;
                        kind_r     <= (sel_kind == 2'd3) ? 2'd0 : sel_kind;
                        gid_r      <= pick;
                        last_grant <= pick;
                        acc        <= 16'd8;
                        idx        <= 4'd0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    idx <= idx + 4'd1;
                    if (last_bit) begin
                        state   <= IDLE;
                        vout    <= acc_nx[15:4] & code_mask(kind_r);
                        vout_id <= gid_r;
                        ack     <= {{(NREQ-1){1'b0}}, 1'b1} << gid_r;
                    end
                end
            endcase
        end
    end
endmodule
